// File: rtl/des_decrypter_iter.sv
// Iterative DES decryption core: one Feistel round per clock, with subkeys K16..K1
// produced on the fly by right-rotating the C/D key halves.
module des_decrypter_iter #(
    parameter int NUM_ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] cipher_in,
    input  logic [63:0] key_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] plain_out,
    output logic        busy
);
    localparam int RW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
    localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS - 1);

    // Tables use FIPS 46-3 numbering: entry n names DES bit n, which is vector bit [W-n].
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SBOX [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
          0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
          15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
          3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
          13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
          1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
          13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
          3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
          14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
          11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
          10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
          4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
          13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
          6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
          1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
          2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

    function automatic logic [63:0] perm_64(input logic [63:0] x, input bit final_perm);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++)
            y[6'(63 - i)] = x[6'(64 - (final_perm ? FP_T[6'(i)] : IP_T[6'(i)]))];
        return y;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] k);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[6'(55 - i)] = k[6'(64 - PC1_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] cd);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = cd[6'(56 - PC2_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] subkey);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] y;
        logic [5:0]  six;
        s = '0;
        y = '0;
        for (int i = 0; i < 48; i++) x[6'(47 - i)] = r[5'(32 - E_T[6'(i)])];
        x = x ^ subkey;
        // Row is the outer bit pair of each 6-bit group, column the inner four.
        for (int b = 0; b < 8; b++) begin
            six = x[6'(42 - 6 * b) +: 6];
            s[5'(28 - 4 * b) +: 4] = 4'(SBOX[3'(b)][{six[5], six[0], six[4:1]}]);
        end
        for (int i = 0; i < 32; i++) y[5'(31 - i)] = s[5'(32 - P_T[5'(i)])];
        return y;
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] v, input logic [1:0] n);
        case (n)
            2'd1:    return {v[0], v[27:1]};
            2'd2:    return {v[1:0], v[27:2]};
            default: return v;
        endcase
    endfunction

    // Right-rotation schedule undoes the encrypt-side left shifts, newest first.
    function automatic logic [1:0] rot_amt(input logic [RW-1:0] r);
        if (r == '0) return 2'd0;
        if (r == RW'(1) || r == RW'(8) || r == RW'(15)) return 2'd1;
        return 2'd2;
    endfunction

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t        state, state_nx;
    logic [RW-1:0] round_q;
    logic [31:0]   l_q, r_q, r_new;
    logic [27:0]   c_q, d_q, c_rot, d_rot;

    assign c_rot = rotr(c_q, rot_amt(round_q));
    assign d_rot = rotr(d_q, rot_amt(round_q));
    assign r_new = l_q ^ feistel(r_q, perm_pc2({c_rot, d_rot}));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        state_nx  = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid) state_nx = ROUND;
            end
            ROUND: begin
                busy = 1'b1;
                if (round_q == LAST_ROUND) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round_q   <= '0;
            l_q       <= '0;
            r_q       <= '0;
            c_q       <= '0;
            d_q       <= '0;
            plain_out <= '0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    {l_q, r_q} <= perm_64(cipher_in, 1'b0);
                    {c_q, d_q} <= perm_pc1(key_in);
                    round_q    <= '0;
                end
                ROUND: begin
                    c_q     <= c_rot;
                    d_q     <= d_rot;
                    l_q     <= r_q;
                    r_q     <= r_new;
                    round_q <= round_q + 1'b1;
                    if (round_q == LAST_ROUND) plain_out <= perm_64({r_new, r_q}, 1'b1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_des_decrypter_iter.sv
// Directed bench for des_decrypter_iter: known-answer vectors, latency, backpressure,
// input stability, mid-operation reset and back-to-back blocks.
module tb_des_decrypter_iter;
    localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] CT1  = 64'h85E813540F0AB405;
    localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;
    localparam logic [63:0] KEY2 = 64'h0E329232EA6D0D73;
    localparam logic [63:0] CT2  = 64'h0000000000000000;
    localparam logic [63:0] PT2  = 64'h8787878787878787;
    localparam logic [63:0] PAR  = 64'h0101010101010101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] cipher_in = '0;
    logic [63:0] key_in = '0;
    logic        in_ready, out_valid, busy;
    logic [63:0] plain_out;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    des_decrypter_iter #(.NUM_ROUNDS(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .cipher_in(cipher_in), .key_in(key_in), .out_valid(out_valid),
        .out_ready(out_ready), .plain_out(plain_out), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Presents a block and returns the cycle number of its accept edge.
    task automatic accept(input logic [63:0] c, input logic [63:0] k, input bit keep,
                          output int edge_cyc);
        int guard;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b1; cipher_in = c; key_in = k;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout in_ready=%b want=1", in_ready);
        end
        @(posedge clk);
        #1;
        edge_cyc = cyc;
        if (!keep) in_valid = 1'b0;
    endtask

    // Returns the index of the clock period (accept edge = 0) in which out_valid is first high.
    task automatic wait_done(input int edge_cyc, output int lat);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!out_valid && guard < 200);
        if (!out_valid) begin
            n_vec++; n_err++;
            $display("FAIL done_timeout out_valid=%b want=1", out_valid);
        end
        lat = cyc + 1 - edge_cyc;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || plain_out !== 64'h0) begin
            n_err++;
            $display("FAIL reset_state in_ready=%b out_valid=%b busy=%b plain=%h want 0/0/0/0",
                     in_ready, out_valid, busy, plain_out);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release in_ready=%b out_valid=%b busy=%b want 1/0/0",
                     in_ready, out_valid, busy);
        end
    endtask

    task automatic test_latency_backpressure();
        int a, lat;
        out_ready = 1'b0;
        accept(CT1, KEY1, 1'b0, a);
        wait_done(a, lat);
        n_vec++;
        if (lat !== 17) begin n_err++; $display("FAIL v1_latency got=%0d want=17", lat); end
        n_vec++;
        if (plain_out !== PT1) begin n_err++; $display("FAIL v1_plain got=%h want=%h", plain_out, PT1); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b1 || plain_out !== PT1 || in_ready !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL hold_cycle%0d out_valid=%b plain=%h in_ready=%b busy=%b want 1/%h/0/0",
                         i, out_valid, plain_out, in_ready, busy, PT1);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL hold_release out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_vector2_parity();
        int a, lat;
        out_ready = 1'b1;
        accept(CT2, KEY2, 1'b0, a);
        wait_done(a, lat);
        n_vec++;
        if (plain_out !== PT2) begin n_err++; $display("FAIL v2_plain got=%h want=%h", plain_out, PT2); end
        accept(CT2, KEY2 ^ PAR, 1'b0, a);
        wait_done(a, lat);
        n_vec++;
        if (plain_out !== PT2) begin n_err++; $display("FAIL v2_parity_plain got=%h want=%h", plain_out, PT2); end
        n_vec++;
        if (lat !== 17) begin n_err++; $display("FAIL v2_latency got=%0d want=17", lat); end
    endtask

    task automatic test_input_stability();
        int a, lat;
        out_ready = 1'b1;
        accept(CT1, KEY1, 1'b0, a);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            n_vec++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL stab_round%0d busy=%b in_ready=%b want 1/0", k, busy, in_ready);
            end
            if (k >= 3 && k <= 10) begin
                cipher_in = ~CT1;
                key_in    = KEY2;
                in_valid  = (k % 2 == 1);
            end else begin
                in_valid = 1'b0;
            end
        end
        wait_done(a, lat);
        n_vec++;
        if (plain_out !== PT1 || lat !== 17) begin
            n_err++;
            $display("FAIL stab_result plain=%h lat=%0d want %h/17", plain_out, lat, PT1);
        end
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL stab_no_second out_valid=%b in_ready=%b busy=%b want 0/1/0",
                     out_valid, in_ready, busy);
        end
    endtask

    task automatic test_mid_reset();
        int a, lat;
        out_ready = 1'b1;
        accept(CT1, KEY1, 1'b0, a);
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || plain_out !== 64'h0) begin
            n_err++;
            $display("FAIL midrst_async out_valid=%b busy=%b in_ready=%b plain=%h want 0/0/0/0",
                     out_valid, busy, in_ready, plain_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_release out_valid=%b busy=%b in_ready=%b want 0/0/1",
                     out_valid, busy, in_ready);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL midrst_idle%0d out_valid=%b want 0", i, out_valid);
            end
        end
        accept(CT2, KEY2, 1'b0, a);
        wait_done(a, lat);
        n_vec++;
        if (plain_out !== PT2) begin n_err++; $display("FAIL midrst_v2 got=%h want=%h", plain_out, PT2); end
    endtask

    task automatic test_back_to_back();
        int a1, a2, lat;
        out_ready = 1'b1;
        accept(CT1, KEY1, 1'b1, a1);
        cipher_in = CT2;
        key_in    = KEY2;
        wait_done(a1, lat);
        n_vec++;
        if (plain_out !== PT1 || lat !== 17) begin
            n_err++;
            $display("FAIL b2b_first plain=%h lat=%0d want %h/17", plain_out, lat, PT1);
        end
        n_vec++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_done_ready got=%b want=0", in_ready); end
        accept(CT2, KEY2, 1'b0, a2);
        n_vec++;
        if (a2 - a1 !== 18) begin n_err++; $display("FAIL b2b_spacing got=%0d want=18", a2 - a1); end
        wait_done(a2, lat);
        n_vec++;
        if (plain_out !== PT2 || lat !== 17) begin
            n_err++;
            $display("FAIL b2b_second plain=%h lat=%0d want %h/17", plain_out, lat, PT2);
        end
    endtask

    initial begin
        test_reset();
        test_latency_backpressure();
        test_vector2_parity();
        test_input_stability();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
